// File: rtl/drac_pkg.sv
// Shared SIMD issue types: instruction record, op classification and sequencer slot states.
package drac_pkg;

  localparam int SIMD_MUL_LAT = 2;

  typedef enum logic [3:0] {
    VADD    = 4'd0,
    VSUB    = 4'd1,
    VAND    = 4'd2,
    VOR     = 4'd3,
    VXOR    = 4'd4,
    VSLL    = 4'd5,
    VSRL    = 4'd6,
    VMUL    = 4'd7,
    VMULH   = 4'd8,
    VMULHU  = 4'd9,
    VMULHSU = 4'd10
  } instr_type_t;

  typedef struct packed {
    logic        valid;
    instr_type_t instr_type;
    logic [4:0]  vd;
    logic [15:0] tag;
  } rr_exe_simd_instr_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } seq_state_t;

  function automatic logic is_simd_mul(input instr_type_t op);
    return op inside {VMUL, VMULH, VMULHU, VMULHSU};
  endfunction

endpackage

// File: rtl/simd_mul_tracker.sv
// Fixed-depth shadow of the vmul pipeline: one {valid, instr} per stage, head = retiring op.
module simd_mul_tracker
  import drac_pkg::*;
#(
  parameter int MUL_LAT = SIMD_MUL_LAT
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               flush,
  input  logic               push,
  input  rr_exe_simd_instr_t push_instr,
  output logic               head_valid,
  output rr_exe_simd_instr_t head_instr
);

  logic [MUL_LAT-1:0] valid_reg;
  logic [MUL_LAT-1:0] valid_next;
  rr_exe_simd_instr_t instr_reg  [MUL_LAT];
  rr_exe_simd_instr_t instr_next [MUL_LAT];

  genvar gi;
  generate
    for (gi = 0; gi < MUL_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_entry
        assign valid_next[gi] = push;
        assign instr_next[gi] = push_instr;
      end else begin : g_shift
        assign valid_next[gi] = valid_reg[gi-1];
        assign instr_next[gi] = instr_reg[gi-1];
      end
    end
  endgenerate

  // Only the valid bits need clearing; payload is ignored while invalid.
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
    instr_reg <= instr_next;
  end

  assign head_valid = valid_reg[MUL_LAT-1];
  assign head_instr = instr_reg[MUL_LAT-1];

endmodule

// File: rtl/simd_fu_sequencer.sv
// SIMD FU issue sequencer: single issue slot plus vmul tracker arbitrating the FU result mux.
// Optional performance counters are built when SIMD_SEQ_PERF_EN is defined.
module simd_fu_sequencer
  import drac_pkg::*;
#(
  parameter int MUL_LAT = SIMD_MUL_LAT,
  parameter int PERF_W  = 32
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               flush_i,
  input  logic               instr_valid_i,
  input  rr_exe_simd_instr_t instr_i,
  output logic               instr_ready_o,
  output rr_exe_simd_instr_t fu_instr_o,
  output rr_exe_simd_instr_t fu_sel_instr_o,
  output logic               result_valid_o,
  output rr_exe_simd_instr_t result_instr_o,
  output logic [PERF_W-1:0]  perf_issue_o,
  output logic [PERF_W-1:0]  perf_stall_o
);

  // rstn_i is active-high despite its name.
  logic srst;
  assign srst = rstn_i;

  seq_state_t         state_reg, state_next;
  rr_exe_simd_instr_t slot_reg, slot_next;
  logic               slot_mul;
  logic               slot_free;
  logic               nonmul_retire;
  logic               ready;
  logic               accept;
  logic               push;
  logic               head_valid;
  rr_exe_simd_instr_t head_instr;

  assign slot_mul = is_simd_mul(slot_reg.instr_type);
  assign push     = (state_reg == ISSUE) && slot_mul;

  simd_mul_tracker #(
    .MUL_LAT (MUL_LAT)
  ) u_tracker (
    .clk        (clk_i),
    .srst       (srst),
    .flush      (flush_i),
    .push       (push),
    .push_instr (slot_reg),
    .head_valid (head_valid),
    .head_instr (head_instr)
  );

  always_comb begin
    state_next    = state_reg;
    slot_next     = slot_reg;
    slot_free     = 1'b0;
    nonmul_retire = 1'b0;
    case (state_reg)
      EMPTY: slot_free = 1'b1;
      ISSUE: begin
        if (slot_mul) begin
          slot_free = 1'b1;
        end else if (!head_valid) begin
          nonmul_retire = 1'b1;
          slot_free     = 1'b1;
        end else begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        // A retiring mul owns the result mux; the held op just waits.
        if (!head_valid) begin
          nonmul_retire = 1'b1;
          slot_free     = 1'b1;
        end
      end
      default: slot_free = 1'b1;
    endcase

    ready  = !flush_i && !srst && slot_free;
    accept = instr_valid_i && ready;

    if (slot_free) begin
      state_next = accept ? ISSUE : EMPTY;
      if (accept) begin
        slot_next = instr_i;
      end
    end
    if (flush_i) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst) begin
      state_reg <= EMPTY;
      slot_reg  <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
    end
  end

  assign instr_ready_o  = ready;
  assign fu_instr_o     = (!srst && state_reg != EMPTY) ? slot_reg : '0;
  assign result_valid_o = !srst && (head_valid || nonmul_retire);
  assign fu_sel_instr_o = srst          ? '0 :
                          head_valid    ? head_instr :
                          nonmul_retire ? slot_reg : '0;
  assign result_instr_o = fu_sel_instr_o;

`ifdef SIMD_SEQ_PERF_EN
  logic [PERF_W-1:0] perf_issue_reg;
  logic [PERF_W-1:0] perf_stall_reg;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (srst) begin
      perf_issue_reg <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (result_valid_o) begin
        perf_issue_reg <= perf_issue_reg + 1'b1;
      end
      if (state_reg == HOLD) begin
        perf_stall_reg <= perf_stall_reg + 1'b1;
      end
    end
  end

  assign perf_issue_o = perf_issue_reg;
  assign perf_stall_o = perf_stall_reg;
`else
  assign perf_issue_o = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_simd_fu_sequencer.sv
// Randomised scoreboard bench for simd_fu_sequencer with a cycle-numbered retirement model.
module tb_simd_fu_sequencer;
  import drac_pkg::*;

  localparam int L  = 2;
  localparam int PW = 32;
`ifdef SIMD_SEQ_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rstn_i = 1'b1;
  logic               flush_i = 1'b0;
  logic               instr_valid_i = 1'b0;
  rr_exe_simd_instr_t instr_i = '0;
  logic               instr_ready_o;
  rr_exe_simd_instr_t fu_instr_o;
  rr_exe_simd_instr_t fu_sel_instr_o;
  logic               result_valid_o;
  rr_exe_simd_instr_t result_instr_o;
  logic [PW-1:0]      perf_issue_o;
  logic [PW-1:0]      perf_stall_o;

  always #5 clk = ~clk;

  simd_fu_sequencer #(
    .MUL_LAT (L),
    .PERF_W  (PW)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .flush_i        (flush_i),
    .instr_valid_i  (instr_valid_i),
    .instr_i        (instr_i),
    .instr_ready_o  (instr_ready_o),
    .fu_instr_o     (fu_instr_o),
    .fu_sel_instr_o (fu_sel_instr_o),
    .result_valid_o (result_valid_o),
    .result_instr_o (result_instr_o),
    .perf_issue_o   (perf_issue_o),
    .perf_stall_o   (perf_stall_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int serial = 1;

  typedef struct {
    int                 cyc;
    rr_exe_simd_instr_t ins;
  } sb_t;
  sb_t sb[$];

  // Reference model: expected retire cycles are derived from the timing rules directly.
  bit                 mul_ret[int];
  int                 busy_until = 0;
  bit                 nm_valid = 1'b0;
  int                 nm_issue = 0;
  int                 nm_retire = 0;
  rr_exe_simd_instr_t nm_ins = '0;
  bit                 acc_valid = 1'b0;
  int                 acc_cyc = 0;
  rr_exe_simd_instr_t acc_ins = '0;
  int                 exp_ret = 0;
  int                 exp_stall = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic bit is_mul_ref(rr_exe_simd_instr_t ins);
    return ins.instr_type inside {VMUL, VMULH, VMULHU, VMULHSU};
  endfunction

  function automatic rr_exe_simd_instr_t mk(instr_type_t op);
    rr_exe_simd_instr_t r;
    r.valid      = 1'b1;
    r.instr_type = op;
    r.vd         = 5'($urandom);
    r.tag        = 16'(serial);
    serial++;
    return r;
  endfunction

  function automatic void sb_insert(int c, rr_exe_simd_instr_t ins);
    sb_t e;
    int  idx;
    e.cyc = c;
    e.ins = ins;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endfunction

  task automatic model_cycle();
    int                 x;
    int                 c;
    bit                 exp_rdy;
    rr_exe_simd_instr_t exp_fu;
    x = cyc;
    exp_rdy = !flush_i && !rstn_i && (x >= busy_until);
    chk("ready", 64'(instr_ready_o), 64'(exp_rdy));
    exp_fu = '0;
    if (!rstn_i) begin
      if (acc_valid && acc_cyc == x - 1 && is_mul_ref(acc_ins)) exp_fu = acc_ins;
      else if (nm_valid && nm_issue <= x && x <= nm_retire) exp_fu = nm_ins;
    end
    chk("fu_instr", 64'(fu_instr_o), 64'(exp_fu));
    chk("perf_issue", 64'(perf_issue_o), PERF_ON ? 64'(PW'(exp_ret)) : 64'd0);
    chk("perf_stall", 64'(perf_stall_o), PERF_ON ? 64'(PW'(exp_stall)) : 64'd0);

    if (rstn_i) begin
      mul_ret.delete();
      sb.delete();
      nm_valid   = 1'b0;
      acc_valid  = 1'b0;
      busy_until = 0;
      exp_ret    = 0;
      exp_stall  = 0;
      return;
    end

    if (nm_valid && nm_issue < x && x <= nm_retire) exp_stall++;
    if (mul_ret.exists(x) || (nm_valid && nm_retire == x)) exp_ret++;
    if (nm_valid && x >= nm_retire) nm_valid = 1'b0;

    if (instr_valid_i && instr_ready_o) begin
      acc_valid = 1'b1;
      acc_cyc   = x;
      acc_ins   = instr_i;
      if (is_mul_ref(instr_i)) begin
        mul_ret[x + 1 + L] = 1'b1;
        sb_insert(x + 1 + L, instr_i);
      end else begin
        c = x + 1;
        while (mul_ret.exists(c)) c++;
        sb_insert(c, instr_i);
        nm_valid   = 1'b1;
        nm_issue   = x + 1;
        nm_retire  = c;
        nm_ins     = instr_i;
        busy_until = c;
      end
      $display("accept cyc=%0d type=%s tag=%0d", x, instr_i.instr_type.name(), instr_i.tag);
    end

    if (flush_i) begin
      mul_ret.delete();
      nm_valid = 1'b0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc > x) sb.delete(i);
      end
      busy_until = x + 1;
    end
  endtask

  task automatic step(input bit v, input rr_exe_simd_instr_t ins, input bit fl, input bit rs);
    @(posedge clk);
    cyc++;
    #1;
    instr_valid_i = v;
    instr_i       = ins;
    flush_i       = fl;
    rstn_i        = rs;
    @(negedge clk);
    model_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic send(input instr_type_t op);
    step(1'b1, mk(op), 1'b0, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents (or should present) a result.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc == 0) continue;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL retire_missed cyc=%0d got=none want=tag%0d@%0d", cyc, sb[0].ins.tag, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (rstn_i) begin
        chk("valid_in_reset", 64'(result_valid_o), 64'd0);
        chk("sel_in_reset", 64'(fu_sel_instr_o), 64'd0);
        while (sb.size() > 0 && sb[0].cyc <= cyc) void'(sb.pop_front());
      end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
        chk("result_valid", 64'(result_valid_o), 64'd1);
        chk("sel_instr", 64'(fu_sel_instr_o), 64'(sb[0].ins));
        chk("result_instr", 64'(result_instr_o), 64'(sb[0].ins));
        $display("retire cyc=%0d type=%s tag=%0d", cyc, sb[0].ins.instr_type.name(), sb[0].ins.tag);
        void'(sb.pop_front());
      end else begin
        chk("result_idle", 64'(result_valid_o), 64'd0);
        chk("sel_idle", 64'(fu_sel_instr_o), 64'd0);
      end
    end
  end

  initial begin
    logic [3:0] k;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
    idle(2);

    send(VADD);                  idle(3);
    send(VMUL);                  idle(4);
    send(VMUL); idle(1); send(VXOR); idle(5);
    for (int i = 0; i < 4; i++) send(VMUL);
    idle(5);
    send(VMUL); send(VMULH);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(5);
    send(VADD);                  idle(4);

    for (int i = 0; i < 600; i++) begin
      k = 4'($urandom_range(0, 10));
      if (i == 300 || i == 301) begin
        step(1'b0, '0, 1'b0, 1'b1);
      end else begin
        step($urandom_range(0, 9) < 7, mk(instr_type_t'(k)),
             $urandom_range(0, 99) < 3, 1'b0);
      end
    end
    idle(L + 4);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
